// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control bus between the instruction register/datapath and the multi-cycle control FSM
interface multicycle_control_if #(
  parameter int ALUOP_W = 3
);
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               zero;
  logic               mem_ready;
  logic               PCWrite;
  logic               IorD;
  logic               IRWrite;
  logic               MemRead;
  logic               MemWrite;
  logic               RegWrite;
  logic               RegDst;
  logic               MemtoReg;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         PCSource;
  logic [ALUOP_W-1:0] ALUOp;
  logic               instr_done;
  logic               illegal;
  logic [3:0]         state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output PCWrite, IorD, IRWrite, MemRead, MemWrite, RegWrite, RegDst, MemtoReg,
           ALUSrcA, ALUSrcB, PCSource, ALUOp, instr_done, illegal, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  PCWrite, IorD, IRWrite, MemRead, MemWrite, RegWrite, RegDst, MemtoReg,
           ALUSrcA, ALUSrcB, PCSource, ALUOp, instr_done, illegal, state
  );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS main control FSM with memory ready handshake
module multicycle_control #(
  parameter int ALUOP_W       = 3,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_control_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3'b001);
  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(3'b110);
  localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(3'b111);

  state_t state_q, state_d;

  logic               rdy;
  logic [ALUOP_W-1:0] funct_alu;
  logic               pc_write, iord, ir_write, mem_read, mem_write, reg_write;
  logic               reg_dst, memto_reg, alu_src_a, done, ill;
  logic [1:0]         alu_src_b, pc_source;
  logic [ALUOP_W-1:0] alu_op;

  // Without the handshake every memory access is treated as completing at once.
  assign rdy = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    funct_alu = ALU_ADD;
    case (bus.funct)
      FN_ADD:  funct_alu = ALU_ADD;
      FN_SUB:  funct_alu = ALU_SUB;
      FN_AND:  funct_alu = ALU_AND;
      FN_OR:   funct_alu = ALU_OR;
      FN_SLT:  funct_alu = ALU_SLT;
      default: funct_alu = ALU_ADD;
    endcase
  end

  always_comb begin
    state_d   = S_FETCH;
    pc_write  = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    reg_dst   = 1'b0;
    memto_reg = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    pc_source = 2'b00;
    alu_op    = ALU_ADD;
    done      = 1'b0;
    ill       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = rdy;
        pc_write  = rdy;
        state_d   = rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (bus.opcode)
          OP_RTYPE:      state_d = S_EXEC;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_ADDI:       state_d = S_ADDIEX;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          default: begin
            state_d = S_FETCH;
            ill     = 1'b1;
            done    = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = rdy ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memto_reg = 1'b1;
        reg_write = 1'b1;
        done      = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        done      = rdy;
        state_d   = rdy ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = funct_alu;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        done      = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_source = 2'b01;
        pc_write  = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
        done      = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        done      = 1'b1;
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
        done      = 1'b1;
      end
      default: alu_op = '0;
    endcase
  end

  // Reset masks every output combinationally so an in-flight store is cut off in the same cycle.
  assign bus.PCWrite    = pc_write  & ~reset;
  assign bus.IorD       = iord      & ~reset;
  assign bus.IRWrite    = ir_write  & ~reset;
  assign bus.MemRead    = mem_read  & ~reset;
  assign bus.MemWrite   = mem_write & ~reset;
  assign bus.RegWrite   = reg_write & ~reset;
  assign bus.RegDst     = reg_dst   & ~reset;
  assign bus.MemtoReg   = memto_reg & ~reset;
  assign bus.ALUSrcA    = alu_src_a & ~reset;
  assign bus.ALUSrcB    = reset ? 2'b00 : alu_src_b;
  assign bus.PCSource   = reset ? 2'b00 : pc_source;
  assign bus.ALUOp      = reset ? '0 : alu_op;
  assign bus.instr_done = done & ~reset;
  assign bus.illegal    = ill  & ~reset;
  assign bus.state      = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic reset2 = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_if #(.ALUOP_W(3)) if1 ();
  multicycle_control_if #(.ALUOP_W(4)) if2 ();

  multicycle_control #(.ALUOP_W(3), .MEM_HANDSHAKE(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(if1.master)
  );
  multicycle_control #(.ALUOP_W(4), .MEM_HANDSHAKE(1'b0)) dut2 (
    .clk(clk), .reset(reset2), .bus(if2.master)
  );

  localparam logic [3:0] A_AND = 4'h0, A_OR = 4'h1, A_ADD = 4'h2, A_SUB = 4'h6, A_SLT = 4'h7;
  localparam int K_R = 0, K_LW = 1, K_SW = 2, K_ADDI = 3, K_BEQ = 4, K_BNE = 5, K_J = 6, K_ILL = 7;

  int checks = 0;
  int errors = 0;
  logic [22:0] q1[$];
  logic [22:0] q2[$];

  function automatic logic [22:0] v(input logic [3:0] st, input logic pcw, iord, irw, mrd, mwr,
                                    input logic rw, rd, m2r, asa, input logic [1:0] asb, pcs,
                                    input logic [3:0] aop, input logic done, ill);
    return {st, pcw, iord, irw, mrd, mwr, rw, rd, m2r, asa, asb, pcs, aop, done, ill};
  endfunction

  function automatic logic [3:0] alu_ref(input logic [5:0] fn);
    case (fn)
      6'b100000: return A_ADD;
      6'b100010: return A_SUB;
      6'b100100: return A_AND;
      6'b100101: return A_OR;
      6'b101010: return A_SLT;
      default:   return A_ADD;
    endcase
  endfunction

  function automatic logic [5:0] op_of(input int kind);
    case (kind)
      K_R:     return 6'b000000;
      K_LW:    return 6'b100011;
      K_SW:    return 6'b101011;
      K_ADDI:  return 6'b001000;
      K_BEQ:   return 6'b000100;
      K_BNE:   return 6'b000101;
      default: return 6'b000010;
    endcase
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    for (int k = K_R; k <= K_J; k++) if (op == op_of(k)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [5:0] rand_illegal();
    logic [5:0] r;
    do r = 6'($urandom); while (is_legal(r));
    return r;
  endfunction

  function automatic logic [5:0] r6();
    return 6'($urandom);
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // One clock cycle: drive inputs just after the edge and queue what that cycle must show.
  task automatic cyc(input int d, input logic r, input logic [5:0] op, fn,
                     input logic z, rdy, input logic [22:0] e);
    @(posedge clk);
    #1;
    if (d == 1) begin
      reset = r; if1.opcode = op; if1.funct = fn; if1.zero = z; if1.mem_ready = rdy;
      q1.push_back(e);
    end else begin
      reset2 = r; if2.opcode = op; if2.funct = fn; if2.zero = z; if2.mem_ready = 1'b0;
      q2.push_back(e);
    end
  endtask

  // Expected trace of one instruction; kind K_ILL takes its opcode from fn.
  task automatic run_instr(input int d, input int kind, input logic [5:0] fn, input logic z,
                           input int mw_in, input bit abort);
    logic [5:0] op;
    logic       ill;
    int         fw, mw;
    op  = (kind == K_ILL) ? fn : op_of(kind);
    ill = (kind == K_ILL);
    fw  = (d == 1) ? int'($urandom_range(0, 2)) : 0;
    mw  = (d == 1) ? mw_in : 0;
    for (int i = 0; i < fw; i++)
      cyc(d, 0, r6(), r6(), rb(), 0, v(0, 0,0,0,1,0, 0,0,0,0, 2'b01, 2'b00, A_ADD, 0, 0));
    cyc(d, 0, r6(), r6(), rb(), 1, v(0, 1,0,1,1,0, 0,0,0,0, 2'b01, 2'b00, A_ADD, 0, 0));
    cyc(d, 0, op, ill ? r6() : fn, rb(), rb(),
        v(1, 0,0,0,0,0, 0,0,0,0, 2'b11, 2'b00, A_ADD, ill, ill));
    case (kind)
      K_R: begin
        cyc(d, 0, op, fn, rb(), rb(), v(6, 0,0,0,0,0, 0,0,0,1, 2'b00, 2'b00, alu_ref(fn), 0, 0));
        cyc(d, 0, r6(), r6(), rb(), rb(), v(7, 0,0,0,0,0, 1,1,0,0, 2'b00, 2'b00, A_ADD, 1, 0));
      end
      K_LW: begin
        cyc(d, 0, op, fn, rb(), rb(), v(2, 0,0,0,0,0, 0,0,0,1, 2'b10, 2'b00, A_ADD, 0, 0));
        for (int i = 0; i < mw; i++)
          cyc(d, 0, r6(), r6(), rb(), 0, v(3, 0,1,0,1,0, 0,0,0,0, 2'b00, 2'b00, A_ADD, 0, 0));
        cyc(d, 0, r6(), r6(), rb(), 1, v(3, 0,1,0,1,0, 0,0,0,0, 2'b00, 2'b00, A_ADD, 0, 0));
        cyc(d, 0, r6(), r6(), rb(), rb(), v(4, 0,0,0,0,0, 1,0,1,0, 2'b00, 2'b00, A_ADD, 1, 0));
      end
      K_SW: begin
        cyc(d, 0, op, fn, rb(), rb(), v(2, 0,0,0,0,0, 0,0,0,1, 2'b10, 2'b00, A_ADD, 0, 0));
        for (int i = 0; i < mw; i++)
          cyc(d, 0, r6(), r6(), rb(), 0, v(5, 0,1,0,0,1, 0,0,0,0, 2'b00, 2'b00, A_ADD, 0, 0));
        if (abort) begin
          cyc(d, 1, r6(), r6(), rb(), 0, '0);
          cyc(d, 1, r6(), r6(), rb(), 0, '0);
        end else begin
          cyc(d, 0, r6(), r6(), rb(), 1, v(5, 0,1,0,0,1, 0,0,0,0, 2'b00, 2'b00, A_ADD, 1, 0));
        end
      end
      K_ADDI: begin
        cyc(d, 0, op, fn, rb(), rb(), v(9, 0,0,0,0,0, 0,0,0,1, 2'b10, 2'b00, A_ADD, 0, 0));
        cyc(d, 0, r6(), r6(), rb(), rb(), v(10, 0,0,0,0,0, 1,0,0,0, 2'b00, 2'b00, A_ADD, 1, 0));
      end
      K_BEQ, K_BNE: begin
        cyc(d, 0, op, fn, z, rb(),
            v(8, (kind == K_BEQ) ? z : ~z, 0,0,0,0, 0,0,0,1, 2'b00, 2'b01, A_SUB, 1, 0));
      end
      K_J: begin
        cyc(d, 0, r6(), r6(), rb(), rb(), v(11, 1,0,0,0,0, 0,0,0,0, 2'b00, 2'b10, A_ADD, 1, 0));
      end
      default: ;
    endcase
  endtask

  initial begin : mon1
    logic [22:0] e, a;
    forever begin
      @(negedge clk);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        a = {if1.state, if1.PCWrite, if1.IorD, if1.IRWrite, if1.MemRead, if1.MemWrite,
             if1.RegWrite, if1.RegDst, if1.MemtoReg, if1.ALUSrcA, if1.ALUSrcB, if1.PCSource,
             1'b0, if1.ALUOp, if1.instr_done, if1.illegal};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL dut_cycle t=%0t got %h expected %h", $time, a, e);
        end
      end
    end
  end

  initial begin : mon2
    logic [22:0] e, a;
    forever begin
      @(negedge clk);
      if (q2.size() > 0) begin
        e = q2.pop_front();
        a = {if2.state, if2.PCWrite, if2.IorD, if2.IRWrite, if2.MemRead, if2.MemWrite,
             if2.RegWrite, if2.RegDst, if2.MemtoReg, if2.ALUSrcA, if2.ALUSrcB, if2.PCSource,
             if2.ALUOp, if2.instr_done, if2.illegal};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL dut2_cycle t=%0t got %h expected %h", $time, a, e);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout got running expected finished");
    $fatal(1);
  end

  initial begin : stim
    logic [5:0] fns[6];
    logic [5:0] fn;
    int kind;
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
    if1.opcode = '0; if1.funct = '0; if1.zero = 1'b0; if1.mem_ready = 1'b0;
    if2.opcode = '0; if2.funct = '0; if2.zero = 1'b0; if2.mem_ready = 1'b0;

    cyc(1, 1, 0, 0, 0, 0, '0);
    cyc(1, 1, 0, 0, 0, 0, '0);
    foreach (fns[i]) run_instr(1, K_R, fns[i], 0, 0, 0);
    run_instr(1, K_BEQ, 0, 1, 0, 0);
    run_instr(1, K_BEQ, 0, 0, 0, 0);
    run_instr(1, K_BNE, 0, 1, 0, 0);
    run_instr(1, K_BNE, 0, 0, 0, 0);
    run_instr(1, K_J, 0, 0, 0, 0);
    run_instr(1, K_ILL, 6'b111111, 0, 0, 0);
    run_instr(1, K_LW, 0, 0, 0, 0);
    run_instr(1, K_SW, 0, 0, 2, 0);
    run_instr(1, K_ADDI, 0, 0, 0, 0);
    run_instr(1, K_SW, 0, 0, 2, 1);
    run_instr(1, K_LW, 0, 0, 1, 0);

    for (int n = 0; n < 150; n++) begin
      kind = int'($urandom_range(0, 7));
      fn = ($urandom_range(0, 1) == 0) ? fns[$urandom_range(0, 5)] : r6();
      if (kind == K_ILL) fn = rand_illegal();
      run_instr(1, kind, fn, rb(), int'($urandom_range(0, 3)),
                (kind == K_SW) && ($urandom_range(0, 9) == 0));
    end

    cyc(2, 1, 0, 0, 0, 0, '0);
    cyc(2, 1, 0, 0, 0, 0, '0);
    run_instr(2, K_LW, 0, 0, 0, 0);
    foreach (fns[i]) run_instr(2, K_R, fns[i], 0, 0, 0);
    run_instr(2, K_SW, 0, 0, 0, 0);
    run_instr(2, K_BNE, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d pending expected 0/0", q1.size(), q2.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
